// File: rtl/chirp_seq_pkg.sv
// Shared definitions for the FMC150 chirp/ADC capture sequencer.
// Contents:
//   seq_state_t     - sequencer FSM states
//   DEF_*           - default widths and timeout used by the top module
//   MIN_ADC_LOW     - minimum adc_enable low time between two chirps, in aclk cycles
package chirp_seq_pkg;

  localparam int DEF_CNT_W          = 32;
  localparam int DEF_DLY_W          = 16;
  localparam int DEF_IDX_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  // The ADC stream derives tlast from the falling edge of adc_enable, so the
  // window must stay low long enough for the edge detector to see it.
  localparam int MIN_ADC_LOW = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PRE,
    CHIRP,
    POST,
    GAP
  } seq_state_t;

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable down-counter used to time the PRE lead and the POST tail.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - number of cycles the phase should last
//   done        - high on the last cycle of the phase
// A phase loaded with N lasts N cycles; N=0 and N=1 both last a single cycle.
module seq_delay_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/chirp_capture_sequencer.sv
// Sequences the FMC150 chirp DAC and the ADC capture window for the GPR.
// Ports:
//   aclk, aresetn            - AXI clock, asynchronous active-low reset
//   start, abort, clear_err  - control pulses
//   num_chirps, pri_cycles,
//   pre_cycles, post_cycles  - frame configuration, latched when start is accepted
//   chirp_ready, chirp_done  - chirp generator handshake (already on aclk)
//   chirp_init, chirp_enable,
//   adc_enable               - DAC/ADC datapath controls
//   busy, frame_done,
//   chirp_index              - frame status
//   timeout_err, overrun_err - sticky error flags
module chirp_capture_sequencer
  import chirp_seq_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DLY_W          = DEF_DLY_W,
  parameter int IDX_W          = DEF_IDX_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] num_chirps,
  input  logic [CNT_W-1:0] pri_cycles,
  input  logic [DLY_W-1:0] pre_cycles,
  input  logic [DLY_W-1:0] post_cycles,
  input  logic             chirp_ready,
  input  logic             chirp_done,
  input  logic             clear_err,
  output logic             chirp_init,
  output logic             chirp_enable,
  output logic             adc_enable,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W-1:0] chirp_index,
  output logic             timeout_err,
  output logic             overrun_err
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       GAP_MIN  = 2'(MIN_ADC_LOW - 1);

  seq_state_t state, next_state;

  logic [IDX_W-1:0] num_q;
  logic [CNT_W-1:0] pri_q;
  logic [DLY_W-1:0] pre_q, post_q;

  logic [CNT_W-1:0] pri_cnt, pri_target, tmo_cnt;
  logic [1:0]       gap_cnt;
  logic             gap_min_met, last_chirp;

  logic             cfg_latch, init_set, index_clear, index_inc, frame_set;
  logic             timeout_set, overrun_set, pri_clear, dly_load, dly_done;
  logic [DLY_W-1:0] dly_value;

  seq_delay_counter #(.W(DLY_W)) u_delay (
    .clk        (aclk),
    .rst_n      (aresetn),
    .load       (dly_load),
    .load_value (dly_value),
    .done       (dly_done)
  );

  // GAP hands over to ARM, which always costs one more cycle before PRE.
  // Leaving GAP when the counter holds pri_cycles-2 lets it reach
  // pri_cycles-1 in ARM, so PRE re-enters exactly pri_cycles after the
  // previous PRE when chirp_ready is already high.
  assign pri_target  = (pri_q < CNT_W'(2)) ? '0 : pri_q - CNT_W'(2);
  assign last_chirp  = (num_q != '0) && (chirp_index == num_q - IDX_W'(1));
  // GAP plus the mandatory ARM cycle together give the minimum low time.
  assign gap_min_met = (gap_cnt >= GAP_MIN);

  assign busy         = (state != IDLE);
  assign chirp_enable = (state == CHIRP);
  assign adc_enable   = (state == PRE) || (state == CHIRP) || (state == POST);

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the one-cycle strobes that drive the datapath
  // registers. abort beats every other event while busy.
  always_comb begin
    next_state  = state;
    cfg_latch   = 1'b0;
    init_set    = 1'b0;
    index_clear = 1'b0;
    index_inc   = 1'b0;
    frame_set   = 1'b0;
    timeout_set = 1'b0;
    overrun_set = 1'b0;
    pri_clear   = 1'b0;
    dly_load    = 1'b0;
    dly_value   = pre_q;
    if ((state != IDLE) && abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            next_state  = ARM;
            cfg_latch   = 1'b1;
            init_set    = 1'b1;
            index_clear = 1'b1;
          end
        end
        ARM: begin
          if (chirp_ready) begin
            next_state = PRE;
            pri_clear  = 1'b1;
            dly_load   = 1'b1;
            dly_value  = pre_q;
          end
        end
        PRE: begin
          if (dly_done) begin
            next_state = CHIRP;
          end
        end
        CHIRP: begin
          if (chirp_done) begin
            if (post_q == '0) begin
              next_state = GAP;
            end else begin
              next_state = POST;
              dly_load   = 1'b1;
              dly_value  = post_q;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            next_state  = IDLE;
            timeout_set = 1'b1;
          end
        end
        POST: begin
          if (dly_done) begin
            next_state = GAP;
          end
        end
        GAP: begin
          if (gap_min_met && (pri_cnt >= pri_target)) begin
            overrun_set = (pri_cnt > pri_target);
            if (last_chirp) begin
              next_state = IDLE;
              frame_set  = 1'b1;
            end else begin
              next_state = ARM;
              index_inc  = 1'b1;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Configuration snapshot, counters, status pulses and sticky errors.
  // The PRI counter saturates instead of wrapping so a very long chirp can
  // never alias back into a valid-looking period.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      num_q       <= '0;
      pri_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      pri_cnt     <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      chirp_init  <= 1'b0;
      frame_done  <= 1'b0;
      chirp_index <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (cfg_latch) begin
        num_q  <= num_chirps;
        pri_q  <= pri_cycles;
        pre_q  <= pre_cycles;
        post_q <= post_cycles;
      end
      if (pri_clear) begin
        pri_cnt <= '0;
      end else if (pri_cnt != '1) begin
        pri_cnt <= pri_cnt + CNT_W'(1);
      end
      tmo_cnt <= (state == CHIRP) ? tmo_cnt + CNT_W'(1) : '0;
      if (state == GAP) begin
        if (gap_cnt != 2'b11) begin
          gap_cnt <= gap_cnt + 2'd1;
        end
      end else begin
        gap_cnt <= 2'd1;
      end
      chirp_init <= init_set;
      frame_done <= frame_set;
      if (index_clear) begin
        chirp_index <= '0;
      end else if (index_inc) begin
        chirp_index <= chirp_index + IDX_W'(1);
      end
      timeout_err <= timeout_set | (timeout_err & ~clear_err);
      overrun_err <= overrun_set | (overrun_err & ~clear_err);
    end
  end

endmodule
